// File: rtl/rr_arb_oh.sv
// ---------------------------------------------------------------------------
// rr_arb_oh
//
// Round-robin arbiter. It merges InputWidth valid/ready request channels onto
// one output channel and sits directly upstream of the one-hot data mux.
// Every cycle it computes a one-hot grant. That grant drives the mux select
// (gnt_oh_o) and the payload AND-OR.
//
// Rotation is fair and work-conserving:
//   - Priority starts at ptr_q and wraps modulo InputWidth.
//   - On every accepted transfer, ptr_q moves to one past the winner.
//
// Configuration macro: RR_ARB_OH_OUTREG_EN
//   undefined : combinational bypass. A grant that is back-pressured
//               (out_valid_o & ~out_ready_i) is locked. It stays locked until
//               the downstream accepts it, and new requests are ignored
//               meanwhile.
//   defined   : a single-entry output register follows the mux.
//               Arbitration runs whenever the register is empty or draining.
//               The grant is consumed in the cycle it is made, so no lock is
//               needed.
//
// Parameters:
//   InputWidth  number of requesters (>= 2)
//   DataWidth   payload width per requester
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester valid
//   req_ready_o  per-requester ready (at most one bit set)
//   req_data_i   per-requester payload
//   gnt_oh_o     one-hot (or zero) grant, mux select
//   gnt_idx_o    binary index of the granted requester, 0 when no grant
//   out_valid_o  merged valid
//   out_ready_i  downstream ready
//   out_data_o   payload of the granted requester
// ---------------------------------------------------------------------------
module rr_arb_oh #(
  parameter int InputWidth = 4,
  parameter int DataWidth  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [InputWidth-1:0]                req_valid_i,
  output logic [InputWidth-1:0]                req_ready_o,
  input  logic [InputWidth-1:0][DataWidth-1:0] req_data_i,
  output logic [InputWidth-1:0]                gnt_oh_o,
  output logic [$clog2(InputWidth)-1:0]        gnt_idx_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [DataWidth-1:0]                 out_data_o
);

  localparam int IdxWidth = $clog2(InputWidth);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(InputWidth - 1);

  logic [IdxWidth-1:0]   ptr_q;
  logic [IdxWidth-1:0]   ptr_d;
  logic [InputWidth-1:0] hi_mask;
  logic [InputWidth-1:0] masked_req;
  logic [InputWidth-1:0] pick_req;
  logic [InputWidth-1:0] cand_oh;
  logic [InputWidth-1:0] gnt_sel;
  logic [IdxWidth-1:0]   gnt_idx;
  logic [DataWidth-1:0]  mux_data;
  logic                  handshake;

  // Round-robin candidate.
  // hi_mask keeps the requesters at or above the pointer. If any of them is
  // valid, the lowest such index wins. Otherwise the search wraps around and
  // the lowest valid index overall wins. Walking the vector downwards and
  // overwriting on every set bit leaves the lowest set bit as the winner.
  always_comb begin
    hi_mask = '0;
    for (int j = 0; j < InputWidth; j++) begin
      hi_mask[j] = (IdxWidth'(j) >= ptr_q);
    end
    masked_req = req_valid_i & hi_mask;
    pick_req   = (|masked_req) ? masked_req : req_valid_i;
    cand_oh    = '0;
    for (int j = InputWidth - 1; j >= 0; j--) begin
      if (pick_req[j]) begin
        cand_oh    = '0;
        cand_oh[j] = 1'b1;
      end
    end
  end

  // The visible grant is forced to zero while reset is asserted. This makes
  // every output that derives from it fall to zero asynchronously, even if
  // requesters keep valid high through the reset.
  always_comb begin
    gnt_oh_o = rst_ni ? gnt_sel : '0;
  end

  // Binary encoding of the one-hot grant. Because at most one bit is set,
  // OR-ing the indices of the set bits yields the index. No grant gives 0.
  always_comb begin
    gnt_idx = '0;
    for (int j = 0; j < InputWidth; j++) begin
      if (gnt_oh_o[j]) begin
        gnt_idx = gnt_idx | IdxWidth'(j);
      end
    end
  end

  assign gnt_idx_o = gnt_idx;

  // One-hot AND-OR payload mux. A zero grant gives all-zero data.
  always_comb begin
    mux_data = '0;
    for (int j = 0; j < InputWidth; j++) begin
      mux_data = mux_data | (req_data_i[j] & {DataWidth{gnt_oh_o[j]}});
    end
  end

  // A transfer is accepted from requester k when its valid meets its ready.
  // Ready is only ever raised on the granted bit, so the winner's index is
  // simply gnt_idx.
  assign handshake = |(req_valid_i & req_ready_o);

  // Next pointer: one past the accepted requester, wrapping after the last
  // index. The pointer holds when nothing is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxWidth'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef RR_ARB_OH_OUTREG_EN

  logic                 arb_en;
  logic                 out_valid_q;
  logic [DataWidth-1:0] out_data_q;

  // With the output register present, the grant is always the fresh
  // candidate. It is consumed in the cycle it is made, so nothing is locked.
  always_comb begin
    gnt_sel = cand_oh;
  end

  // Arbitration may proceed only when the output register is empty or is
  // being emptied this cycle. Ready to the winner is gated by that condition.
  assign arb_en      = ~out_valid_q | out_ready_i;
  assign req_ready_o = gnt_oh_o & {InputWidth{arb_en}};
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Output register.
  // Whenever it may accept, it captures the mux result, so an idle arbiter
  // loads an invalid, all-zero entry. While stalled it holds its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (arb_en) begin
      out_valid_q <= |gnt_oh_o;
      out_data_q  <= mux_data;
    end
  end

`ifndef SYNTHESIS
  // A stalled output entry must neither disappear nor change.
  a_outreg_hold : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o))
  ) else $error("rr_arb_oh: output register changed while stalled");
`endif

`else

  logic                  lock_q;
  logic [InputWidth-1:0] gnt_q;

  // While locked, the stored grant replaces the candidate, so requesters that
  // arrive later cannot steal the slot. The stored grant is masked with valid
  // so that a requester breaking its obligation shows up as a dropped
  // out_valid_o instead of a phantom transfer.
  always_comb begin
    gnt_sel = lock_q ? (gnt_q & req_valid_i) : cand_oh;
  end

  assign out_valid_o = |gnt_oh_o;
  assign req_ready_o = gnt_oh_o & {InputWidth{out_ready_i}};
  assign out_data_o  = mux_data;

  // Lock register.
  // A back-pressured grant is captured and held. The lock is released by the
  // handshake that finally accepts it. Reset discards any pending grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
    end else if (out_valid_o && out_ready_i) begin
      lock_q <= 1'b0;
    end else if (out_valid_o) begin
      lock_q <= 1'b1;
      gnt_q  <= gnt_oh_o;
    end
  end

`ifndef SYNTHESIS
  // A requester that is granted but not yet accepted must keep valid high.
  a_locked_valid_held : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (|(req_valid_i & gnt_q))
  ) else $error("rr_arb_oh: locked requester dropped valid");

  // A requester that is granted but not yet accepted must keep its data
  // stable. Seen from the output, the data must not move across a stall.
  a_locked_data_held : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> $stable(out_data_o)
  ) else $error("rr_arb_oh: locked requester changed data");
`endif

`endif

`ifndef SYNTHESIS
  // The grant must be one-hot or zero.
  a_gnt_onehot0 : assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_oh_o)
  ) else $error("rr_arb_oh: grant not one-hot");

  // Ready may only be raised on the granted requester.
  a_ready_in_grant : assert property (
    @(posedge clk_i) disable iff (!rst_ni) ((req_ready_o & ~gnt_oh_o) == '0)
  ) else $error("rr_arb_oh: ready outside grant");
`endif

endmodule

// File: tb/tb_rr_arb_oh.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_oh
//
// Directed and random checks for rr_arb_oh in its default (bypass) build.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later,
// so every comparison happens well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arb_oh;

  localparam int N  = 4;
  localparam int DW = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [N-1:0]         req_valid_i;
  logic [N-1:0]         req_ready_o;
  logic [N-1:0][DW-1:0] req_data_i;
  logic [N-1:0]         gnt_oh_o;
  logic [1:0]           gnt_idx_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DW-1:0]        out_data_o;

  logic [DW-1:0] tb_data [N];

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [N-1:0] valid;
    logic         ready;
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_idx;
    logic         exp_valid;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t vecs [19];

  rr_arb_oh #(
    .InputWidth(N),
    .DataWidth (DW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_data_i (req_data_i),
    .gnt_oh_o   (gnt_oh_o),
    .gnt_idx_o  (gnt_idx_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Builds one table entry.
  function automatic vec_t mk(input logic [N-1:0] v, input logic r,
                              input logic [N-1:0] eg, input logic [1:0] ei,
                              input logic ev, input logic [N-1:0] er);
    vec_t t;
    t.valid     = v;
    t.ready     = r;
    t.exp_gnt   = eg;
    t.exp_idx   = ei;
    t.exp_valid = ev;
    t.exp_ready = er;
    return t;
  endfunction

  // Drives one cycle of inputs on the falling edge, then lets them settle.
  task automatic applyStimulus(input logic [N-1:0] v, input logic r);
    @(negedge clk_i);
    req_valid_i = v;
    out_ready_i = r;
    for (int k = 0; k < N; k++) req_data_i[k] = tb_data[k];
    #1;
  endtask

  // Compares all outputs against the expected values in one comparison.
  task automatic checkOutput(input string name, input logic [N-1:0] eg,
                             input logic [1:0] ei, input logic ev,
                             input logic [N-1:0] er, input logic [DW-1:0] ed);
    vec_count++;
    if (gnt_oh_o !== eg || gnt_idx_o !== ei || out_valid_o !== ev ||
        req_ready_o !== er || out_data_o !== ed) begin
      miss_count++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b ready=%b data=%h, expected gnt=%b idx=%0d valid=%b ready=%b data=%h",
               name, gnt_oh_o, gnt_idx_o, out_valid_o, req_ready_o, out_data_o,
               eg, ei, ev, er, ed);
    end
  endtask

  initial begin
    int m_ptr;
    int m_idx;
    bit m_lock;
    bit found;
    int e_idx;
    logic [N-1:0] v;
    logic         r;
    logic [N-1:0] eg;

    for (int k = 0; k < N; k++) tb_data[k] = 32'hCAFE_0000 + 32'(k + 1) * 32'h0000_1111;
    for (int k = 0; k < N; k++) req_data_i[k] = tb_data[k];
    rst_ni      = 1'b0;
    req_valid_i = '0;
    out_ready_i = 1'b0;
    #1;
    checkOutput("reset_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, '0);
    req_valid_i = 4'b1111;
    out_ready_i = 1'b1;
    #1;
    checkOutput("reset_with_req", 4'b0000, 2'd0, 1'b0, 4'b0000, '0);
    @(negedge clk_i);
    req_valid_i = '0;
    rst_ni      = 1'b1;

    // Fairness, idle, sparse/wrap, then back-pressure lock and release.
    vecs[0]  = mk(4'b1111, 1, 4'b0001, 0, 1, 4'b0001);
    vecs[1]  = mk(4'b1111, 1, 4'b0010, 1, 1, 4'b0010);
    vecs[2]  = mk(4'b1111, 1, 4'b0100, 2, 1, 4'b0100);
    vecs[3]  = mk(4'b1111, 1, 4'b1000, 3, 1, 4'b1000);
    vecs[4]  = mk(4'b1111, 1, 4'b0001, 0, 1, 4'b0001);
    vecs[5]  = mk(4'b1111, 1, 4'b0010, 1, 1, 4'b0010);
    vecs[6]  = mk(4'b1111, 1, 4'b0100, 2, 1, 4'b0100);
    vecs[7]  = mk(4'b1111, 1, 4'b1000, 3, 1, 4'b1000);
    vecs[8]  = mk(4'b0000, 1, 4'b0000, 0, 0, 4'b0000);
    vecs[9]  = mk(4'b0001, 1, 4'b0001, 0, 1, 4'b0001);
    vecs[10] = mk(4'b1001, 1, 4'b1000, 3, 1, 4'b1000);
    vecs[11] = mk(4'b1001, 1, 4'b0001, 0, 1, 4'b0001);
    vecs[12] = mk(4'b0100, 0, 4'b0100, 2, 1, 4'b0000);
    vecs[13] = mk(4'b0110, 0, 4'b0100, 2, 1, 4'b0000);
    vecs[14] = mk(4'b0110, 0, 4'b0100, 2, 1, 4'b0000);
    vecs[15] = mk(4'b1110, 1, 4'b0100, 2, 1, 4'b0100);
    vecs[16] = mk(4'b1110, 1, 4'b1000, 3, 1, 4'b1000);
    vecs[17] = mk(4'b0110, 1, 4'b0010, 1, 1, 4'b0010);
    vecs[18] = mk(4'b0110, 1, 4'b0100, 2, 1, 4'b0100);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx,
                  vecs[i].exp_valid, vecs[i].exp_ready,
                  vecs[i].exp_valid ? tb_data[vecs[i].exp_idx] : '0);
    end

    // Reset in the middle of a locked transfer: the outputs must clear at
    // once, and the pending grant to index 3 must be forgotten.
    applyStimulus(4'b1000, 1'b0);
    checkOutput("lock_pre_reset", 4'b1000, 2'd3, 1'b1, 4'b0000, tb_data[3]);
    @(negedge clk_i);
    req_valid_i = 4'b1111;
    out_ready_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("reset_midstream", 4'b0000, 2'd0, 1'b0, 4'b0000, '0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    req_valid_i = 4'b0011;
    out_ready_i = 1'b1;
    #1;
    checkOutput("post_reset_first", 4'b0001, 2'd0, 1'b1, 4'b0001, tb_data[0]);

    // Random traffic against a reference model. The bench honours the
    // requester obligation: a stalled winner keeps its valid and data.
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_valid_i = '0;
    #1;
    rst_ni = 1'b1;
    m_ptr  = 0;
    m_idx  = 0;
    m_lock = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v = 4'($urandom_range(0, 15));
      if (m_lock) v[m_idx] = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (!(m_lock && k == m_idx) && $urandom_range(0, 3) == 0) tb_data[k] = $urandom;
      end
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, r);
      found = 1'b0;
      e_idx = 0;
      if (m_lock) begin
        found = 1'b1;
        e_idx = m_idx;
      end else begin
        for (int off = 0; off < N; off++) begin
          if (!found && v[(m_ptr + off) % N]) begin
            found = 1'b1;
            e_idx = (m_ptr + off) % N;
          end
        end
      end
      eg = found ? (4'b0001 << e_idx) : 4'b0000;
      checkOutput($sformatf("random%0d", cyc), eg, 2'(e_idx), found,
                  (found && r) ? eg : 4'b0000, found ? tb_data[e_idx] : '0);
      if (found && r) begin
        m_ptr  = (e_idx + 1) % N;
        m_lock = 1'b0;
      end else if (found) begin
        m_lock = 1'b1;
        m_idx  = e_idx;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/rr_arb_oh.md
# rr_arb_oh

Round-robin arbiter that merges `InputWidth` valid/ready request channels onto one output channel. It is the stage directly upstream of the one-hot data mux. Each cycle it computes a one-hot grant, which drives the mux select (`gnt_oh_o`) and the payload path. Grant rotation is fair and work-conserving. A grant is locked while the output is back-pressured.

## Interface
- `InputWidth`, 4: number of requesters; ≥ 2.
- `DataWidth`, 32: payload width per requester.
- `clk_i` input 1: single clock; all state on rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req_valid_i` input `[InputWidth-1:0]`: per-requester valid.
- `req_ready_o` output `[InputWidth-1:0]`: per-requester ready; at most one bit set.
- `req_data_i` input `[InputWidth-1:0][DataWidth-1:0]`: per-requester payload.
- `gnt_oh_o` output `[InputWidth-1:0]`: one-hot (or zero) grant; mux select.
- `gnt_idx_o` output `$clog2(InputWidth)`: binary index of granted requester; 0 when no grant.
- `out_valid_o` output 1: merged valid.
- `out_ready_i` input 1: downstream ready.
- `out_data_o` output `DataWidth`: payload of the granted requester.

## Operation
- **Priority pointer `ptr_q`** (`$clog2(InputWidth)` bits, reset 0). Priority is `ptr_q`, `ptr_q+1`, …, wrapping modulo `InputWidth`.
- **Grant candidate:** the first asserted `req_valid_i` bit in priority order. If no request is asserted, the grant is all-zero.
- **Lock:**
  - `lock_q` (reset 0) is set when `out_valid_o & ~out_ready_i` and no output register is present.
  - While `lock_q`=1, the stored `gnt_q` (reset 0) is used instead of the candidate.
  - `lock_q` clears on the handshake.
- **Requester obligation:** a requester that is granted and not yet accepted must hold `req_valid_i` and `req_data_i` stable. Dropping either is a protocol violation, checked by a simulation assertion.
- **Handshake:** occurs at index k when `req_valid_i[k] & req_ready_o[k]`. On a handshake, `ptr_q <= (k+1) mod InputWidth`. When k = `InputWidth-1`, `ptr_q` wraps to 0. Without a handshake, `ptr_q` holds.
- **Payload selection:** one-hot AND-OR of `req_data_i` under `gnt_oh_o`. A zero grant yields all-zero data.
- **Bypass mode:**
  - `out_valid_o = |gnt_oh_o`
  - `req_ready_o = gnt_oh_o & {InputWidth{out_ready_i}}`
- **New requests while locked:** ignored until the locked grant is accepted.
- **Reset mid-transfer:**
  - The pending grant is discarded.
  - `ptr_q` returns to 0.
  - All outputs return to their reset values asynchronously.

## Timing
- **Bypass latency:** 0 cycles. `gnt_oh_o`, `out_valid_o`, `out_data_o`, and `req_ready_o` are combinational from `req_valid_i`/`out_ready_i` plus state.
- **Throughput:** 1 transfer/cycle.
- **Fairness:** with all inputs continuously valid, each requester is served exactly once per `InputWidth` consecutive transfers.
- **Reset values:**
  - `gnt_oh_o`=0 and `gnt_idx_o`=0 whenever no request is valid.
  - `req_ready_o`=0 and `out_valid_o`=0 during reset.
  - `out_data_o`=0 during reset (registered mode: register cleared).

## Configuration
- **`RR_ARB_OH_OUTREG_EN` defined:** a single-entry output register is inserted after the mux.
  - `out_valid_o` and `out_data_o` are driven from flops; both reset to 0.
  - Arbitration is enabled when the register is empty or is draining this cycle (`~out_valid_o | out_ready_i`), and `req_ready_o = gnt_oh_o` under that enable.
  - The lock is unused; the grant is consumed on the same cycle it is made.
  - Latency is 1 cycle; throughput is still 1/cycle.
  - `gnt_oh_o`/`gnt_idx_o` still reflect the current combinational grant.
- **`RR_ARB_OH_OUTREG_EN` undefined:** combinational bypass with the lock, as described above.

## Test plan
- **Reset:** assert `rst_ni`=0 mid-stream with valid requests → all outputs are 0 immediately; after release, the first grant goes to the lowest valid index ≥ 0.
- **Fairness:** `InputWidth`=4, `req_valid_i`=4'b1111 held for 8 cycles with `out_ready_i`=1 → `gnt_idx_o` sequence is 0,1,2,3,0,1,2,3.
- **Sparse and wrap:** `req_valid_i`=4'b1001 with `ptr_q`=1 → grant index 3, then `ptr_q`=0, next grant index 0.
- **Backpressure lock (bypass):**
  - Stimulus: grant to index 2; `out_ready_i`=0 for 3 cycles while `req_valid_i[1]` rises.
  - Required: `gnt_oh_o` stays 4'b0100 and `out_data_o` stays stable. After `out_ready_i`=1, the next grant is index 3 if valid, else index 0/1 in rotation.
- **Registered mode:** `RR_ARB_OH_OUTREG_EN`, single request index 1 with data 0xDEADBEEF → `out_valid_o`=1 with 0xDEADBEEF one cycle after the handshake. With back-to-back requests and `out_ready_i`=1 → one transfer per cycle.
- **Scoreboard (random):** 10000 cycles of random valid/ready → every accepted payload matches the granted requester's data, `gnt_oh_o` is always one-hot or zero, and the protocol assertions never fire.
